// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return-address stack with checkpoint/recover for branch mispredict repair.
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif
module ras_ckpt #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = `CPU_ADDR_BITS,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] pop_addr,
  output logic              pop_valid,
  output logic              full,
  output logic [PTR_W-1:0]  ckpt_ptr,
  output logic [CNT_W-1:0]  ckpt_count,
  output logic [ADDR_W-1:0] ckpt_top,
  input  logic              recover,
  input  logic [PTR_W-1:0]  recover_ptr,
  input  logic [CNT_W-1:0]  recover_count,
  input  logic [ADDR_W-1:0] recover_top,
  input  logic              flush
);
  logic [ADDR_W-1:0] stack [DEPTH];
  logic [PTR_W-1:0]  ptr, top;
  logic [CNT_W-1:0]  count, rec_cnt;
  assign top        = ptr - PTR_W'(1);
  assign pop_valid  = count != '0;
  assign full       = count == CNT_W'(DEPTH);
  assign pop_addr   = pop_valid ? stack[top] : '0;
  assign ckpt_ptr   = ptr;
  assign ckpt_count = count;
  assign ckpt_top   = pop_addr;
  assign rec_cnt    = recover_count > CNT_W'(DEPTH) ? CNT_W'(DEPTH) : recover_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (recover) begin
      ptr   <= recover_ptr;
      count <= rec_cnt;
      if (rec_cnt != '0) stack[recover_ptr - PTR_W'(1)] <= recover_top;
    end else if (push && pop && pop_valid) begin
      stack[top] <= push_addr;
    end else if (push) begin
      // a push onto a full stack silently overwrites the oldest entry
      stack[ptr] <= push_addr;
      ptr        <= ptr + PTR_W'(1);
      count      <= full ? count : count + CNT_W'(1);
    end else if (pop && pop_valid) begin
      ptr   <= top;
      count <= count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed checks of ras_ckpt with DEPTH=4, ADDR_W=32.
module tb_ras_ckpt;
  logic        clk = 0;
  logic        rst_n, push, pop, recover, flush;
  logic [31:0] push_addr, recover_top, pop_addr, ckpt_top;
  logic [1:0]  recover_ptr, ckpt_ptr;
  logic [2:0]  recover_count, ckpt_count;
  logic        pop_valid, full;
  int          checks = 0, errors = 0;
  ras_ckpt #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_addr(push_addr),
    .pop_addr(pop_addr), .pop_valid(pop_valid), .full(full), .ckpt_ptr(ckpt_ptr),
    .ckpt_count(ckpt_count), .ckpt_top(ckpt_top), .recover(recover),
    .recover_ptr(recover_ptr), .recover_count(recover_count),
    .recover_top(recover_top), .flush(flush)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    rst_n = 1; push = 0; pop = 0; push_addr = 0; flush = 0;
    recover = 0; recover_ptr = 0; recover_count = 0; recover_top = 0;
  endtask
  task automatic do_push(input logic [31:0] a);
    push = 1; push_addr = a; cyc();
  endtask
  task automatic do_pop();
    pop = 1; cyc();
  endtask
  task automatic do_rec(input logic [1:0] p, input logic [2:0] c, input logic [31:0] t);
    recover = 1; recover_ptr = p; recover_count = c; recover_top = t; cyc();
  endtask
  initial begin
    rst_n = 0; push = 0; pop = 0; push_addr = 0; flush = 0;
    recover = 0; recover_ptr = 0; recover_count = 0; recover_top = 0;
    #2; rst_n = 0; @(posedge clk); #1; rst_n = 0; cyc();
    chk("rst_pop_addr", pop_addr, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ptr", ckpt_ptr, 0);
    chk("rst_count", ckpt_count, 0);
    chk("rst_top", ckpt_top, 0);
    do_push(32'hA); do_push(32'hB); do_push(32'hC);
    chk("p3_top", pop_addr, 32'hC);
    chk("p3_count", ckpt_count, 3);
    chk("p3_ptr", ckpt_ptr, 3);
    do_pop(); chk("pop1", pop_addr, 32'hB);
    do_pop(); chk("pop2", pop_addr, 32'hA);
    do_pop();
    chk("pop3_valid", pop_valid, 0);
    chk("pop3_addr", pop_addr, 0);
    chk("pop3_count", ckpt_count, 0);
    for (int i = 1; i <= 5; i++) do_push(32'(i));
    chk("wrap_full", full, 1);
    chk("wrap_count", ckpt_count, 4);
    chk("wrap_ptr", ckpt_ptr, 1);
    for (int i = 5; i >= 2; i--) begin
      chk("wrap_pop", pop_addr, 32'(i));
      do_pop();
    end
    chk("wrap_empty", pop_valid, 0);
    chk("wrap_notfull", full, 0);
    chk("wrap_ptr_end", ckpt_ptr, 1);
    flush = 1; cyc();
    chk("flush_ptr", ckpt_ptr, 0);
    do_push(32'hA); do_push(32'hB);
    push = 1; pop = 1; push_addr = 32'hE; cyc();
    chk("pp_top", pop_addr, 32'hE);
    chk("pp_count", ckpt_count, 2);
    chk("pp_ptr", ckpt_ptr, 2);
    do_pop(); chk("pp_pop", pop_addr, 32'hA);
    do_pop();
    do_push(32'hA); do_push(32'hB);
    chk("ck_ptr", ckpt_ptr, 2);
    chk("ck_count", ckpt_count, 2);
    chk("ck_top", ckpt_top, 32'hB);
    do_pop(); do_push(32'hF);
    chk("ck_spec_top", pop_addr, 32'hF);
    do_rec(2, 2, 32'hB);
    chk("rec_top", pop_addr, 32'hB);
    chk("rec_count", ckpt_count, 2);
    do_pop(); chk("rec_pop", pop_addr, 32'hA);
    flush = 1; cyc();
    do_pop();
    chk("empty_pop_count", ckpt_count, 0);
    chk("empty_pop_ptr", ckpt_ptr, 0);
    chk("empty_pop_valid", pop_valid, 0);
    push = 1; pop = 1; push_addr = 32'h55; cyc();
    chk("pp_empty_count", ckpt_count, 1);
    chk("pp_empty_top", pop_addr, 32'h55);
    push = 1; push_addr = 32'h99; do_rec(3, 3, 32'h33);
    chk("recpush_ptr", ckpt_ptr, 3);
    chk("recpush_count", ckpt_count, 3);
    chk("recpush_top", pop_addr, 32'h33);
    do_rec(1, 7, 32'h44);
    chk("recsat_count", ckpt_count, 4);
    chk("recsat_full", full, 1);
    chk("recsat_top", pop_addr, 32'h44);
    flush = 1; do_rec(2, 2, 32'h66);
    chk("flushrec_count", ckpt_count, 0);
    chk("flushrec_ptr", ckpt_ptr, 0);
    chk("flushrec_valid", pop_valid, 0);
    do_push(32'h1); do_push(32'h2); do_push(32'h3);
    rst_n = 0; push = 1; push_addr = 32'h9; cyc();
    chk("mrst_addr", pop_addr, 0);
    chk("mrst_valid", pop_valid, 0);
    chk("mrst_full", full, 0);
    chk("mrst_ptr", ckpt_ptr, 0);
    chk("mrst_count", ckpt_count, 0);
    chk("mrst_top", ckpt_top, 0);
    do_push(32'h7);
    chk("post_rst_top", pop_addr, 32'h7);
    chk("post_rst_count", ckpt_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
